// File: rtl/unidade_controle_multiciclo_if.sv
// Control/datapath bundle for the multicycle control unit:
// decoded IR fields and flags in, register strobes and mux selects out.
interface unidade_controle_multiciclo_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       mdr_write;
  logic       aluout_write;
  logic       reg_write;
  logic       epc_write;
  logic       mem_read;
  logic       mem_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] mem_to_reg;
  logic [1:0] pc_source;
  logic [3:0] state;

  modport master (
    input  opcode, funct3, funct7_5, zero, mem_ready,
    output pc_write, ir_write, mdr_write, aluout_write,
    output reg_write, epc_write, mem_read, mem_write,
    output alu_src_a, alu_src_b, alu_op, mem_to_reg,
    output pc_source, state
  );

  modport slave (
    output opcode, funct3, funct7_5, zero, mem_ready,
    input  pc_write, ir_write, mdr_write, aluout_write,
    input  reg_write, epc_write, mem_read, mem_write,
    input  alu_src_a, alu_src_b, alu_op, mem_to_reg,
    input  pc_source, state
  );
endinterface

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control FSM for the 64-bit processing unit.
// Define UC_TRAP_EN to route illegal instructions through a TRAP cycle.
module unidade_controle_multiciclo #(
  parameter logic [1:0] TRAP_VECTOR_SEL = 2'b10
) (
  input logic clk,
  input logic reset_n,
  unidade_controle_multiciclo_if.master bus
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_LOAD  = 4'd4,
    LOAD_WB   = 4'd5,
    MEM_STORE = 4'd6,
    EXEC_R    = 4'd7,
    EXEC_I    = 4'd8,
    ALU_WB    = 4'd9,
    BRANCH    = 4'd10,
    LUI_WB    = 4'd11,
    TRAP      = 4'd12
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  state_t cur, nxt;

  logic is_r, is_i, is_mem, is_br, is_lui;

  always_comb begin
    is_r   = (bus.opcode == OP_R) &&
             (bus.funct3 == 3'b000 ||
              bus.funct3 == 3'b111 ||
              bus.funct3 == 3'b110);
    is_i   = (bus.opcode == OP_I) &&
             (bus.funct3 == 3'b000);
    is_mem = (bus.opcode == OP_LD ||
              bus.opcode == OP_SD) &&
             (bus.funct3 == 3'b011);
    is_br  = (bus.opcode == OP_BR) &&
             (bus.funct3[2:1] == 2'b00);
    is_lui = (bus.opcode == OP_LUI);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cur <= IDLE;
    else          cur <= nxt;
  end

  always_comb begin
    nxt = IDLE;
    case (cur)
      IDLE:      nxt = FETCH;
      FETCH:     nxt = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        unique case (1'b1)
          is_r:    nxt = EXEC_R;
          is_i:    nxt = EXEC_I;
          is_mem:  nxt = MEM_ADDR;
          is_br:   nxt = BRANCH;
          is_lui:  nxt = LUI_WB;
`ifdef UC_TRAP_EN
          default: nxt = TRAP;
`else
          default: nxt = FETCH;
`endif
        endcase
      end
      // opcode bit 5 separates sd from ld
      MEM_ADDR:  nxt = bus.opcode[5] ? MEM_STORE : MEM_LOAD;
      MEM_LOAD:  nxt = bus.mem_ready ? LOAD_WB : MEM_LOAD;
      LOAD_WB:   nxt = FETCH;
      MEM_STORE: nxt = bus.mem_ready ? FETCH : MEM_STORE;
      EXEC_R:    nxt = ALU_WB;
      EXEC_I:    nxt = ALU_WB;
      ALU_WB:    nxt = FETCH;
      BRANCH:    nxt = FETCH;
      LUI_WB:    nxt = FETCH;
      TRAP:      nxt = FETCH;
      default:   nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.pc_write     = 1'b0;
    bus.ir_write     = 1'b0;
    bus.mdr_write    = 1'b0;
    bus.aluout_write = 1'b0;
    bus.reg_write    = 1'b0;
    bus.epc_write    = 1'b0;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.alu_src_a    = 1'b0;
    bus.alu_src_b    = 2'b00;
    bus.alu_op       = 3'b000;
    bus.mem_to_reg   = 2'b00;
    bus.pc_source    = 2'b00;
    case (cur)
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      DECODE: begin
        bus.alu_src_b    = 2'b10;
        bus.aluout_write = 1'b1;
      end
      EXEC_R: begin
        bus.alu_src_a    = 1'b1;
        bus.aluout_write = 1'b1;
        case (bus.funct3)
          3'b000:  bus.alu_op = bus.funct7_5 ? 3'b001 : 3'b000;
          3'b111:  bus.alu_op = 3'b010;
          3'b110:  bus.alu_op = 3'b011;
          default: bus.alu_op = 3'b000;
        endcase
      end
      EXEC_I, MEM_ADDR: begin
        bus.alu_src_a    = 1'b1;
        bus.alu_src_b    = 2'b10;
        bus.aluout_write = 1'b1;
      end
      ALU_WB:  bus.reg_write = 1'b1;
      MEM_LOAD: begin
        bus.mem_read  = 1'b1;
        bus.mdr_write = bus.mem_ready;
      end
      LOAD_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 2'b01;
      end
      MEM_STORE: bus.mem_write = 1'b1;
      BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 3'b001;
        bus.pc_source = 2'b01;
        bus.pc_write  = bus.funct3[0] ^ bus.zero;
      end
      LUI_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 2'b10;
      end
`ifdef UC_TRAP_EN
      TRAP: begin
        bus.epc_write = 1'b1;
        bus.pc_write  = 1'b1;
        bus.pc_source = TRAP_VECTOR_SEL;
      end
`endif
      default: ;
    endcase
  end

  assign bus.state = cur;

endmodule

// File: doc/unidade_controle_multiciclo.md
# unidade_controle_multiciclo

Multicycle control FSM for the 64-bit processing unit (`unidadeProcessamento`). It decodes the instruction held in IR and sequences the datapath strobes: PC, IR, MDR, ALUOut, register file and memory. It also selects the ALU operands and operation. Memory accesses use a ready handshake, so wait states stretch any memory cycle.

## Interface
- `TRAP_VECTOR_SEL`, default 2'b10: `pc_source` code that selects the trap vector mux input.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `opcode` in 7: IR[6:0].
- `funct3` in 3: IR[14:12].
- `funct7_5` in 1: IR[30].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completed the current read/write this cycle.
- `pc_write`, `ir_write`, `mdr_write`, `aluout_write`, `reg_write`, `epc_write` out 1 each: register load strobes.
- `mem_read`, `mem_write` out 1 each: memory request, held until `mem_ready`.
- `alu_src_a` out 1: 0 = PC, 1 = A.
- `alu_src_b` out 2: 00 = B, 01 = constant 4, 10 = imm.
- `alu_op` out 3: 000 add, 001 sub, 010 and, 011 or.
- `mem_to_reg` out 2: 00 = ALUOut, 01 = MDR, 10 = imm (lui).
- `pc_source` out 2: 00 = ALU result, 01 = ALUOut, 10 = trap vector.
- `state` out 4: current state, for debug.

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_LOAD=4, LOAD_WB=5, MEM_STORE=6, EXEC_R=7, EXEC_I=8, ALU_WB=9, BRANCH=10, LUI_WB=11, TRAP=12. Codes 13–15 go to IDLE.
- Outputs are Moore-decoded from `state`, except where a gate on `mem_ready` or `zero` is listed. Any output not listed for a state is 0.
- **IDLE**: all outputs 0. Next state is FETCH unconditionally.
- **FETCH**:
  - Outputs: `mem_read`=1, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=add, `pc_source`=00.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Go to DECODE when `mem_ready`=1; otherwise stay.
- **DECODE**:
  - Outputs: `alu_src_a`=0, `alu_src_b`=10, `alu_op`=add, `aluout_write`=1. This precomputes the branch target.
  - Dispatch on `opcode`:
    - 0110011 → EXEC_R
    - 0010011 with `funct3`=000 → EXEC_I
    - 0000011 with `funct3`=011 → MEM_ADDR
    - 0100011 with `funct3`=011 → MEM_ADDR
    - 1100011 with `funct3` 000 or 001 → BRANCH
    - 0110111 → LUI_WB
    - anything else → illegal instruction
- **EXEC_R**:
  - Outputs: `alu_src_a`=1, `alu_src_b`=00, `aluout_write`=1.
  - `alu_op`: `funct3`=000 gives add (`funct7_5`=0) or sub (`funct7_5`=1); `funct3`=111 gives and; `funct3`=110 gives or.
  - Any other R-type `funct3` is decided in DECODE as illegal.
  - Next state: ALU_WB.
- **EXEC_I**: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=add, `aluout_write`=1. Next state: ALU_WB.
- **ALU_WB**: `reg_write`=1, `mem_to_reg`=00. Next state: FETCH.
- **MEM_ADDR**: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=add, `aluout_write`=1. Go to MEM_LOAD for a load or MEM_STORE for a store.
- **MEM_LOAD**: `mem_read`=1, `mdr_write`=`mem_ready`. Go to LOAD_WB on `mem_ready`; otherwise stay.
- **LOAD_WB**: `reg_write`=1, `mem_to_reg`=01. Next state: FETCH.
- **MEM_STORE**: `mem_write`=1. Go to FETCH on `mem_ready`; otherwise stay.
- **BRANCH**:
  - Outputs: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=sub, `pc_source`=01.
  - `pc_write` = `zero` for beq, `!zero` for bne.
  - Next state: FETCH.
- **LUI_WB**: `reg_write`=1, `mem_to_reg`=10. Next state: FETCH.

## Timing
- Reset value of every output is 0, and `state`=IDLE.
- Reset is asynchronous, including mid-instruction. Any pending memory request is dropped immediately.
- The first FETCH begins 1 cycle after reset is released.
- Latency per instruction with `mem_ready` tied high:
  - R-type and addi: 4 cycles.
  - ld: 5 cycles.
  - sd: 4 cycles.
  - beq/bne and lui: 3 cycles.
- Each cycle `mem_ready` is low during FETCH, MEM_LOAD or MEM_STORE adds 1 cycle. During that wait the request stays asserted and no strobe fires.
- `mem_ready` outside the memory states is ignored.
- Every strobe is a single-cycle pulse, except `mem_read` and `mem_write`, which are held for the whole request.

## Configuration
- Macro: `UC_TRAP_EN`.
- **Defined**: an illegal instruction goes DECODE → TRAP. TRAP asserts `epc_write`=1, `pc_write`=1 and `pc_source`=`TRAP_VECTOR_SEL` for 1 cycle, then returns to FETCH.
- **Undefined**: an illegal instruction goes DECODE → FETCH and behaves as a NOP. No TRAP cycle occurs and `epc_write` is constant 0.

## Test plan
- **Reset**: hold `reset_n`=0 for 3 cycles, then release. Required: all outputs 0 and `state`=0 during reset; `state`=1 one cycle after release.
- **add with `mem_ready`=1**:
  - opcode 0110011, funct3 000, funct7_5 0.
  - State sequence 1,2,7,9,1.
  - `alu_op`=000 in EXEC_R; `reg_write` high exactly once.
  - Repeat with funct7_5=1: `alu_op`=001.
- **ld with 2 wait cycles**: `mem_ready` low for 2 cycles in MEM_LOAD.
  - State sequence 1,2,3,4,4,4,5,1.
  - `mem_read` high for 3 cycles; `mdr_write` only in the last of them.
- **beq/bne**:
  - beq with `zero`=1: `pc_write`=1 and `pc_source`=01 in BRANCH.
  - beq with `zero`=0: `pc_write`=0.
  - bne inverts both results.
- **Reset mid-sd**: assert `reset_n`=0 in MEM_STORE while `mem_ready`=0. Required: `mem_write` drops to 0 without waiting for a clock edge, and `state`=0.
- **Illegal opcode 1111111**:
  - With `UC_TRAP_EN`: sequence 1,2,12,1, with `epc_write`=1 and `pc_source`=10 in TRAP.
  - Without it: sequence 1,2,1 and `epc_write` never asserts.
